adc_capture_scheduler: RTL and testbench
========================================

ADC_CAPTURE_SCHEDULER -- requirements
Module: adc_capture_scheduler

Interface
REQ-001 Parameter: CNT_W, default 32, width of delay/length/interval counters and config words.
REQ-002 Parameter: NUM_CH, default 4, number of ADC stream channels sequenced.
REQ-003 rf_clk  input  1  RF-domain clock; all logic on rising edge.
REQ-004 rf_reset  input  1  asynchronous, active-low reset.
REQ-005 ext_trigger  input  1  external trigger level, synchronous to rf_clk.
REQ-006 arm  input  1  single-cycle pulse; latches cfg_* and arms the scheduler.
REQ-007 abort  input  1  single-cycle pulse; terminates any sequence.
REQ-008 cfg_delay  input  CNT_W  cycles from trigger edge to first capture.
REQ-009 cfg_length  input  CNT_W  cycles per capture window.
REQ-010 cfg_interval  input  CNT_W  idle cycles between consecutive windows.
REQ-011 cfg_repeats  input  16  number of windows per trigger.
REQ-012 cfg_ch_mask  input  NUM_CH  channels enabled for capture.
REQ-013 ch_tready  input  NUM_CH  per-channel downstream ready.
REQ-014 capture_valid  output  NUM_CH  per-channel tvalid drive to the stream channels.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse on sequence completion.
REQ-017 frame_index  output  16  number of windows completed in current sequence.
REQ-018 overflow  output  NUM_CH  sticky per-channel backpressure-loss flag.

Function
REQ-019 States SHALL be IDLE, ARMED, DELAY, CAPTURE, GAP, WAIT_LOW; encoding free.
REQ-020 IDLE: arm SHALL latch all cfg_* into shadow registers, clear frame_index and overflow, go ARMED; cfg_* changes after that SHALL have no effect.
REQ-021 Latched cfg_repeats=0 and cfg_length=0 SHALL each be treated as 1.
REQ-022 arm outside IDLE SHALL be ignored.
REQ-023 ARMED: trigger edge = ext_trigger 1 this cycle and 0 the previous cycle (registered history, also tracked in IDLE); a level already high at arm SHALL NOT trigger.
REQ-024 Edge at cycle t: delay=0 -> CAPTURE with capture_valid=mask from t+1; delay=D>0 -> DELAY, capture_valid=mask from t+1+D.
REQ-025 CAPTURE: capture_valid SHALL equal latched mask for exactly length consecutive cycles, then 0 unless REQ-026 back-to-back applies.
REQ-026 Window end: frame_index increments by 1; if new frame_index < repeats: interval=0 -> next window starts next cycle (capture_valid continuous), interval=I>0 -> GAP, capture_valid low exactly I cycles.
REQ-027 Final window end: done pulses 1 cycle (cycle after last valid), state WAIT_LOW.
REQ-028 WAIT_LOW: go IDLE on first cycle ext_trigger=0; ext_trigger edges during DELAY/CAPTURE/GAP/WAIT_LOW SHALL be ignored.
REQ-029 overflow[i] SHALL set on any cycle with capture_valid[i]=1 and ch_tready[i]=0; cleared only by accepted arm or reset; capture timing SHALL NOT stall on backpressure.
REQ-030 abort in any state: next cycle IDLE, capture_valid=0, no done pulse, frame_index and overflow hold.
REQ-031 abort and arm same cycle: abort wins, arm discarded.
REQ-032 Counters SHALL be CNT_W wide, count down from latched value, never wrap; max value 2^CNT_W-1 supported.

Reset
REQ-033 rf_reset low SHALL immediately force IDLE, capture_valid=0, busy=0, done=0, frame_index=0, overflow=0, trigger history=0, shadow config=0, regardless of state.
REQ-034 After reset release, first action SHALL require a new arm.

Verification
REQ-035 arm(delay=3,length=4,repeats=1,mask=4'hF), trigger edge at t -> capture_valid=F for t+4..t+7, done at t+8.
REQ-036 delay=0,length=2,interval=3,repeats=3 -> valid t+1..2, t+6..7, t+11..12; frame_index 1,2,3; done t+13.
REQ-037 interval=0,length=2,repeats=2 -> valid continuous 4 cycles, frame_index=2, single done.
REQ-038 ch_tready=4'b1101 during capture, mask=F -> overflow=4'b0010 held after done; cleared by next arm.
REQ-039 abort mid-CAPTURE, or rf_reset low mid-GAP -> capture_valid=0 next cycle / immediately, busy=0, no done.
REQ-040 ext_trigger high before arm and held -> no capture until it falls and rises; trigger held after done -> remains WAIT_LOW, busy=1.

Source files
------------

// File: rtl/adc_capture_scheduler_if.sv
// Control, configuration and stream-status bundle of the ADC capture scheduler.
// The master side (controller or bench) drives triggers/config; the scheduler is the slave.
interface adc_capture_scheduler_if #(
  parameter int CNT_W  = 32,
  parameter int NUM_CH = 4
);
  logic              ext_trigger;
  logic              arm;
  logic              abort;
  logic [CNT_W-1:0]  cfg_delay;
  logic [CNT_W-1:0]  cfg_length;
  logic [CNT_W-1:0]  cfg_interval;
  logic [15:0]       cfg_repeats;
  logic [NUM_CH-1:0] cfg_ch_mask;
  logic [NUM_CH-1:0] ch_tready;
  logic [NUM_CH-1:0] capture_valid;
  logic              busy;
  logic              done;
  logic [15:0]       frame_index;
  logic [NUM_CH-1:0] overflow;

  modport master (
    output ext_trigger, arm, abort,
    output cfg_delay, cfg_length, cfg_interval, cfg_repeats, cfg_ch_mask,
    output ch_tready,
    input  capture_valid, busy, done, frame_index, overflow
  );

  modport slave (
    input  ext_trigger, arm, abort,
    input  cfg_delay, cfg_length, cfg_interval, cfg_repeats, cfg_ch_mask,
    input  ch_tready,
    output capture_valid, busy, done, frame_index, overflow
  );
endinterface

// File: rtl/adc_capture_scheduler.sv
// Trigger-driven capture window sequencer: after an arm and a trigger rising edge it
// opens repeated capture windows on the enabled ADC stream channels with delay/gap timing.
module adc_capture_scheduler #(
  parameter int CNT_W  = 32,
  parameter int NUM_CH = 4
) (
  input logic                   rf_clk,
  input logic                   rf_reset,
  adc_capture_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    DELAY    = 3'd2,
    CAPTURE  = 3'd3,
    GAP      = 3'd4,
    WAIT_LOW = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       frame_q, frame_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              trig_q;

  logic [CNT_W-1:0]  delay_q, delay_d;
  logic [CNT_W-1:0]  length_q, length_d;
  logic [CNT_W-1:0]  interval_q, interval_d;
  logic [15:0]       repeats_q, repeats_d;
  logic [NUM_CH-1:0] mask_q, mask_d;

  logic              trigEdge;
  logic [NUM_CH-1:0] validNow;
  logic [15:0]       frameInc;

  assign trigEdge = bus.ext_trigger & ~trig_q;
  assign validNow = (state_q == CAPTURE) ? mask_q : '0;
  assign frameInc = frame_q + 16'd1;

  assign bus.capture_valid = validNow;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_q;
  assign bus.frame_index   = frame_q;
  assign bus.overflow      = ovf_q;

  // Shadow config stores already-normalised values so zero length/repeats act as one.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    ovf_d      = ovf_q | (validNow & ~bus.ch_tready);
    done_d     = 1'b0;
    delay_d    = delay_q;
    length_d   = length_q;
    interval_d = interval_q;
    repeats_d  = repeats_q;
    mask_d     = mask_q;

    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.arm) begin
            delay_d    = bus.cfg_delay;
            length_d   = (bus.cfg_length == '0) ? CNT_W'(1) : bus.cfg_length;
            interval_d = bus.cfg_interval;
            repeats_d  = (bus.cfg_repeats == 16'd0) ? 16'd1 : bus.cfg_repeats;
            mask_d     = bus.cfg_ch_mask;
            frame_d    = 16'd0;
            ovf_d      = '0;
            state_d    = ARMED;
          end
        end

        ARMED: begin
          if (trigEdge) begin
            if (delay_q == '0) begin
              state_d = CAPTURE;
              cnt_d   = length_q - CNT_W'(1);
            end else begin
              state_d = DELAY;
              cnt_d   = delay_q - CNT_W'(1);
            end
          end
        end

        DELAY: begin
          if (cnt_q == '0) begin
            state_d = CAPTURE;
            cnt_d   = length_q - CNT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        // A window ends on its last valid cycle; the next one may start immediately.
        CAPTURE: begin
          if (cnt_q == '0) begin
            frame_d = frameInc;
            if (frameInc >= repeats_q) begin
              done_d  = 1'b1;
              state_d = WAIT_LOW;
            end else if (interval_q == '0) begin
              cnt_d = length_q - CNT_W'(1);
            end else begin
              state_d = GAP;
              cnt_d   = interval_q - CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        GAP: begin
          if (cnt_q == '0) begin
            state_d = CAPTURE;
            cnt_d   = length_q - CNT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        WAIT_LOW: begin
          if (!bus.ext_trigger) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Trigger history runs in every state so a level already high at arm is not an edge.
  always_ff @(posedge rf_clk or negedge rf_reset) begin
    if (!rf_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      frame_q    <= 16'd0;
      ovf_q      <= '0;
      done_q     <= 1'b0;
      trig_q     <= 1'b0;
      delay_q    <= '0;
      length_q   <= '0;
      interval_q <= '0;
      repeats_q  <= 16'd0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      trig_q     <= bus.ext_trigger;
      delay_q    <= delay_d;
      length_q   <= length_d;
      interval_q <= interval_d;
      repeats_q  <= repeats_d;
      mask_q     <= mask_d;
    end
  end

endmodule

// File: tb/tb_adc_capture_scheduler.sv
// Directed bench for adc_capture_scheduler: a table of full capture sequences with
// hand-computed timing, plus hand-written abort, reset and trigger-level sequences.
module tb_adc_capture_scheduler;

  logic rf_clk;
  logic rf_reset;
  int   totalChecks;
  int   badChecks;

  adc_capture_scheduler_if #(.CNT_W(32), .NUM_CH(4)) bus ();

  adc_capture_scheduler #(.CNT_W(32), .NUM_CH(4)) dut (
    .rf_clk  (rf_clk),
    .rf_reset(rf_reset),
    .bus     (bus)
  );

  initial rf_clk = 1'b0;
  always #5 rf_clk = ~rf_clk;

  // Offsets count falling edges after the one where ext_trigger is raised.
  typedef struct {
    logic [31:0] delay;
    logic [31:0] length;
    logic [31:0] interval;
    logic [15:0] repeats;
    logic [3:0]  mask;
    logic [3:0]  tready;
    int          firstV;
    int          lastV;
    int          countV;
    int          doneOff;
    logic [15:0] frames;
    logic [3:0]  ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic armWith(input logic [31:0] d, input logic [31:0] l, input logic [31:0] i,
                         input logic [15:0] r, input logic [3:0] m);
    bus.cfg_delay    = d;
    bus.cfg_length   = l;
    bus.cfg_interval = i;
    bus.cfg_repeats  = r;
    bus.cfg_ch_mask  = m;
    bus.arm          = 1'b1;
    @(negedge rf_clk);
    bus.arm          = 1'b0;
    bus.cfg_delay    = 32'd7;
    bus.cfg_length   = 32'd9;
    bus.cfg_interval = 32'd5;
    bus.cfg_repeats  = 16'd4;
    bus.cfg_ch_mask  = 4'h0;
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int firstV, lastV, countV, doneOff, maskErr;
    logic [15:0] frameAtDone;
    logic [3:0]  ovfAtDone;
    firstV = -1; lastV = -1; countV = 0; doneOff = -1; maskErr = 0;
    frameAtDone = 16'hffff; ovfAtDone = 4'hx;
    bus.ch_tready = v.tready;
    armWith(v.delay, v.length, v.interval, v.repeats, v.mask);
    checkOutput({tag, "_armBusy"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, "_armFrame"}, 32'(bus.frame_index), 32'd0);
    checkOutput({tag, "_armOvf"}, 32'(bus.overflow), 32'd0);
    bus.ext_trigger = 1'b1;
    for (int off = 1; off <= 200 && doneOff < 0; off++) begin
      @(negedge rf_clk);
      if (bus.capture_valid != 4'h0) begin
        if (firstV < 0) firstV = off;
        lastV = off;
        countV++;
        if (bus.capture_valid != v.mask) maskErr++;
      end
      if (bus.done) begin
        doneOff     = off;
        frameAtDone = bus.frame_index;
        ovfAtDone   = bus.overflow;
      end
    end
    checkOutput({tag, "_doneOff"}, 32'(doneOff), 32'(v.doneOff));
    checkOutput({tag, "_firstValid"}, 32'(firstV), 32'(v.firstV));
    checkOutput({tag, "_lastValid"}, 32'(lastV), 32'(v.lastV));
    checkOutput({tag, "_validCount"}, 32'(countV), 32'(v.countV));
    checkOutput({tag, "_validMask"}, 32'(maskErr), 32'd0);
    checkOutput({tag, "_frames"}, 32'(frameAtDone), 32'(v.frames));
    checkOutput({tag, "_overflow"}, 32'(ovfAtDone), 32'(v.ovf));
    @(negedge rf_clk);
    checkOutput({tag, "_donePulse"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "_waitLowBusy"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, "_ovfHeld"}, 32'(bus.overflow), 32'(v.ovf));
    bus.ext_trigger = 1'b0;
    @(negedge rf_clk);
    checkOutput({tag, "_idleBusy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_idleFrame"}, 32'(bus.frame_index), 32'(v.frames));
  endtask

  initial begin
    int seen;
    totalChecks = 0;
    badChecks   = 0;

    //          delay  length interval repeats mask   tready  first last count done frames ovf
    vecs[0] = '{32'd3, 32'd4, 32'd0, 16'd1, 4'hF, 4'hF, 4,  7,  4, 8,  16'd1, 4'h0};
    vecs[1] = '{32'd0, 32'd2, 32'd3, 16'd3, 4'hF, 4'hF, 1, 12,  6, 13, 16'd3, 4'h0};
    vecs[2] = '{32'd0, 32'd2, 32'd0, 16'd2, 4'hF, 4'hF, 1,  4,  4, 5,  16'd2, 4'h0};
    vecs[3] = '{32'd0, 32'd3, 32'd0, 16'd1, 4'hF, 4'hD, 1,  3,  3, 4,  16'd1, 4'h2};
    vecs[4] = '{32'd1, 32'd0, 32'd0, 16'd0, 4'h5, 4'h0, 2,  2,  1, 3,  16'd1, 4'h5};
    vecs[5] = '{32'd2, 32'd1, 32'd1, 16'd2, 4'hA, 4'hF, 3,  5,  2, 6,  16'd2, 4'h0};

    rf_reset         = 1'b0;
    bus.ext_trigger  = 1'b0;
    bus.arm          = 1'b0;
    bus.abort        = 1'b0;
    bus.cfg_delay    = 32'd0;
    bus.cfg_length   = 32'd0;
    bus.cfg_interval = 32'd0;
    bus.cfg_repeats  = 16'd0;
    bus.cfg_ch_mask  = 4'h0;
    bus.ch_tready    = 4'hF;
    @(negedge rf_clk);
    @(negedge rf_clk);
    checkOutput("rstValid", 32'(bus.capture_valid), 32'd0);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("rstDone", 32'(bus.done), 32'd0);
    checkOutput("rstFrame", 32'(bus.frame_index), 32'd0);
    checkOutput("rstOvf", 32'(bus.overflow), 32'd0);
    rf_reset = 1'b1;
    @(negedge rf_clk);

    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k], $sformatf("vec%0d", k));
    end

    // Trigger already high at arm must wait for a fresh rising edge.
    bus.ch_tready   = 4'hF;
    bus.ext_trigger = 1'b1;
    @(negedge rf_clk);
    armWith(32'd0, 32'd1, 32'd0, 16'd1, 4'hF);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge rf_clk);
      if (bus.capture_valid != 4'h0) seen++;
    end
    checkOutput("lvlNoCapture", 32'(seen), 32'd0);
    checkOutput("lvlArmedBusy", 32'(bus.busy), 32'd1);
    bus.ext_trigger = 1'b0;
    @(negedge rf_clk);
    bus.ext_trigger = 1'b1;
    @(negedge rf_clk);
    checkOutput("lvlValid", 32'(bus.capture_valid), 32'hF);
    @(negedge rf_clk);
    checkOutput("lvlDone", 32'(bus.done), 32'd1);
    @(negedge rf_clk);
    @(negedge rf_clk);
    checkOutput("lvlHeldBusy", 32'(bus.busy), 32'd1);
    bus.ext_trigger = 1'b0;
    @(negedge rf_clk);
    checkOutput("lvlReleaseBusy", 32'(bus.busy), 32'd0);

    // Abort in the middle of a capture window.
    armWith(32'd0, 32'd5, 32'd0, 16'd1, 4'hF);
    bus.ext_trigger = 1'b1;
    @(negedge rf_clk);
    @(negedge rf_clk);
    checkOutput("abtPreValid", 32'(bus.capture_valid), 32'hF);
    bus.abort = 1'b1;
    @(negedge rf_clk);
    bus.abort = 1'b0;
    checkOutput("abtValid", 32'(bus.capture_valid), 32'd0);
    checkOutput("abtBusy", 32'(bus.busy), 32'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.done) seen++;
      @(negedge rf_clk);
    end
    checkOutput("abtNoDone", 32'(seen), 32'd0);
    checkOutput("abtFrameHold", 32'(bus.frame_index), 32'd0);
    bus.ext_trigger = 1'b0;
    @(negedge rf_clk);

    // Reset asserted during the gap between windows.
    armWith(32'd0, 32'd1, 32'd5, 16'd2, 4'hF);
    bus.ext_trigger = 1'b1;
    @(negedge rf_clk);
    @(negedge rf_clk);
    @(negedge rf_clk);
    checkOutput("rgFrameBefore", 32'(bus.frame_index), 32'd1);
    checkOutput("rgGapValid", 32'(bus.capture_valid), 32'd0);
    rf_reset = 1'b0;
    #1;
    checkOutput("rgBusy", 32'(bus.busy), 32'd0);
    checkOutput("rgFrame", 32'(bus.frame_index), 32'd0);
    checkOutput("rgDone", 32'(bus.done), 32'd0);
    @(negedge rf_clk);
    rf_reset        = 1'b1;
    bus.ext_trigger = 1'b0;
    @(negedge rf_clk);
    bus.ext_trigger = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge rf_clk);
      if (bus.capture_valid != 4'h0 || bus.busy) seen++;
    end
    checkOutput("rgNeedsArm", 32'(seen), 32'd0);
    bus.ext_trigger = 1'b0;
    @(negedge rf_clk);

    // Abort and arm together: abort wins and the arm is discarded.
    bus.abort = 1'b1;
    armWith(32'd0, 32'd1, 32'd0, 16'd1, 4'hF);
    bus.abort = 1'b0;
    checkOutput("armAbortBusy", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
